fw_run_controller: RTL

- Sequences one complete Floyd-Warshall kernel run against a single shared path memory port.
- Run order: preload path memory from a loader ROM, pulse the kernel start strobe, give the kernel exclusive use of the port for a fixed cycle budget, then stream the whole memory out for checking.
- Sits between the kernel's read/write memory port and the memory read/write models. The kernel has a static schedule and no done output, so this block owns all timing.

---
 rtl/fw_run_controller_if.sv | 28 ++
 rtl/fw_run_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fw_run_controller_if.sv
// Shared path-memory port between the run controller and the memory model.
// master drives address/enables/write data, slave returns read data.
interface fw_run_controller_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_addr,
    output mem_rd_en,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/fw_run_controller.sv
// Floyd-Warshall run controller: preload from ROM, launch kernel,
// grant the shared port for RUN_CYCLES, then dump memory.
// Ports: clk/rst/go, busy/done status, loader ROM (ld_*),
// kernel port (t, k_*), shared memory (mem), dump stream (dump_*).
module fw_run_controller #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int RUN_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                ld_rd_en,
  output logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                t,
  input  logic [ADDR_W-1:0]   k_addr,
  input  logic                k_rd_en,
  input  logic                k_wr_en,
  input  logic [DATA_W-1:0]   k_wr_data,
  output logic [DATA_W-1:0]   k_rd_data,
  output logic                k_err,
  fw_run_controller_if.master mem,
  output logic                dump_valid,
  output logic [ADDR_W-1:0]   dump_addr,
  output logic [DATA_W-1:0]   dump_data
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LAUNCH,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     rcnt;
  logic              k_err_q;

  logic              grant;
  logic              k_req;
  logic              cnt_lo;
  logic              cnt_nz;
  logic [ADDR_W-1:0] cnt_a;
  logic [ADDR_W-1:0] cnt_pa;

  assign grant  = (state == S_LAUNCH) || (state == S_RUN);
  assign k_req  = k_rd_en | k_wr_en;
  // INIT/DUMP issue on cnt < DEPTH and
  // consume the previous beat on cnt > 0.
  assign cnt_lo = cnt < CNT_LAST;
  assign cnt_nz = cnt != '0;
  assign cnt_a  = ADDR_W'(cnt);
  assign cnt_pa = ADDR_W'(cnt - CW'(1));

  assign k_rd_data = mem.mem_rd_data;
  assign k_err     = k_err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rcnt    <= '0;
      k_err_q <= 1'b0;
    end else begin
      if (k_req && !grant) k_err_q <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_INIT;
            cnt   <= '0;
          end
        end
        S_INIT: begin
          if (cnt == CNT_LAST) begin
            state <= S_LAUNCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LAUNCH: begin
          state <= S_RUN;
          rcnt  <= '0;
        end
        S_RUN: begin
          if (rcnt == RUN_LAST) begin
            state <= S_DUMP;
            cnt   <= '0;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        S_DUMP: begin
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Everything is forced low while rst is high, so a reset
  // mid-run can never leak a write into memory.
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    t               = 1'b0;
    ld_rd_en        = 1'b0;
    ld_addr         = '0;
    mem.mem_addr    = '0;
    mem.mem_rd_en   = 1'b0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_data = '0;
    dump_valid      = 1'b0;
    dump_addr       = '0;
    dump_data       = '0;
    if (!rst) begin
      busy = (state != S_IDLE);
      unique case (state)
        S_INIT: begin
          if (cnt_lo) begin
            ld_rd_en = 1'b1;
            ld_addr  = cnt_a;
          end
          if (cnt_nz) begin
            mem.mem_wr_en   = 1'b1;
            mem.mem_addr    = cnt_pa;
            mem.mem_wr_data = ld_data;
          end
        end
        S_LAUNCH, S_RUN: begin
          t               = (state == S_LAUNCH);
          mem.mem_addr    = k_addr;
          mem.mem_rd_en   = k_rd_en;
          mem.mem_wr_en   = k_wr_en;
          mem.mem_wr_data = k_wr_data;
        end
        S_DUMP: begin
          if (cnt_lo) begin
            mem.mem_rd_en = 1'b1;
            mem.mem_addr  = cnt_a;
          end
          if (cnt_nz) begin
            dump_valid = 1'b1;
            dump_addr  = cnt_pa;
            dump_data  = mem.mem_rd_data;
          end
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
